// File: rtl/mvm_pkg.sv
// Shared sizes, state encoding and element types for the MVM output stage.
package mvm_pkg;

  localparam int NUM_BIT = 8;
  localparam int DIM     = 8;
  localparam int ACC_BIT = 16;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  typedef logic signed [ACC_BIT-1:0] acc_t;
  typedef logic signed [NUM_BIT-1:0] act_t;

endpackage

// File: rtl/requant_unit.sv
// Combinational requantizer: rounding arithmetic right shift, optional ReLU,
// then saturation of one accumulator value to the output element width.
module requant_unit
  import mvm_pkg::*;
#(
  parameter int SHIFT   = 4,
  parameter bit RELU_EN = 1'b1
) (
  input  acc_t i_acc,
  output act_t o_act,
  output logic o_sat
);

  // One extra bit keeps the rounding add from wrapping at the positive limit.
  localparam logic signed [ACC_BIT:0] RND  = (ACC_BIT+1)'((1 << SHIFT) >> 1);
  localparam logic signed [ACC_BIT:0] MAXV = (ACC_BIT+1)'((1 << (NUM_BIT-1)) - 1);
  localparam logic signed [ACC_BIT:0] MINV = ~MAXV;

  logic signed [ACC_BIT:0] sum;
  logic signed [ACC_BIT:0] r;

  always_comb begin
    sum   = (ACC_BIT+1)'(i_acc) + RND;
    r     = sum >>> SHIFT;
    o_sat = 1'b0;
    if (RELU_EN && r[ACC_BIT]) begin
      o_act = '0;
    end else if (r > MAXV) begin
      o_act = MAXV[NUM_BIT-1:0];
      o_sat = 1'b1;
    end else if (r < MINV) begin
      o_act = MINV[NUM_BIT-1:0];
      o_sat = 1'b1;
    end else begin
      o_act = r[NUM_BIT-1:0];
    end
  end

endmodule

// File: rtl/mvm_requant_out.sv
// MVM output stage: captures the result vector on the falling edge of the
// core busy flag, requantizes it, and streams it out one element per handshake.
module mvm_requant_out #(
  parameter int NUM_BIT = mvm_pkg::NUM_BIT,
  parameter int DIM     = mvm_pkg::DIM,
  parameter int ACC_BIT = mvm_pkg::ACC_BIT,
  parameter int SHIFT   = 4,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                        i_clk_rqOut,
  input  logic                        i_rst_rqOut,
  input  logic [DIM-1:0][ACC_BIT-1:0] i_y_vector,
  input  logic                        i_isAcc,
  output logic                        o_busy,
  output logic [NUM_BIT-1:0]          o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [$clog2(DIM)-1:0]      o_idx,
  output logic                        o_last,
  output logic                        o_sat,
  output logic                        o_overrun
);
  import mvm_pkg::*;

  localparam int               IDX_W    = $clog2(DIM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  state_t                      state_q, state_d;
  logic                        isacc_q;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        overrun_q, overrun_d;
  logic [DIM-1:0][NUM_BIT-1:0] data_q, data_d;
  logic [DIM-1:0]              sat_q, sat_d;

  logic [DIM-1:0][NUM_BIT-1:0] rq_data;
  logic [DIM-1:0]              rq_sat;
  logic                        streaming, fall, xfer, last_xfer, capture;

  for (genvar g = 0; g < DIM; g++) begin : g_rq
    requant_unit #(
      .SHIFT   (SHIFT),
      .RELU_EN (RELU_EN)
    ) u_rq (
      .i_acc (i_y_vector[g]),
      .o_act (rq_data[g]),
      .o_sat (rq_sat[g])
    );
  end

  always_comb begin
    streaming = (state_q == STREAM);
    fall      = isacc_q & ~i_isAcc;
    xfer      = streaming & i_ready;
    last_xfer = xfer & (idx_q == LAST_IDX);
    // A vector landing on the final handshake refills the buffer back-to-back.
    capture   = fall & (~streaming | last_xfer);

    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    sat_d     = sat_q;
    overrun_d = overrun_q | (fall & streaming & ~last_xfer);

    if (capture) begin
      state_d = STREAM;
      idx_d   = '0;
      data_d  = rq_data;
      sat_d   = rq_sat;
    end else if (last_xfer) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (xfer) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge i_clk_rqOut or posedge i_rst_rqOut) begin
    if (i_rst_rqOut) begin
      state_q   <= IDLE;
      isacc_q   <= 1'b0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      data_q    <= '0;
      sat_q     <= '0;
    end else begin
      state_q   <= state_d;
      isacc_q   <= i_isAcc;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      data_q    <= data_d;
      sat_q     <= sat_d;
    end
  end

  assign o_valid   = streaming;
  assign o_busy    = streaming;
  assign o_idx     = idx_q;
  assign o_data    = streaming ? data_q[idx_q] : '0;
  assign o_sat     = streaming & sat_q[idx_q];
  assign o_last    = streaming & (idx_q == LAST_IDX);
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_mvm_requant_out.sv
// Bench for mvm_requant_out: two instances (ReLU on / off) share stimulus and
// are checked by a negedge monitor against a queue-based reference model.
module tb_mvm_requant_out;

  localparam int DIM   = 8;
  localparam int NB    = 8;
  localparam int AB    = 16;
  localparam int SHIFT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, isacc, ready;
  logic [DIM-1:0][AB-1:0] y;

  logic          r_busy, r_valid, r_last, r_sat, r_ovr;
  logic [NB-1:0] r_data;
  logic [2:0]    r_idx;
  logic          n_busy, n_valid, n_last, n_sat, n_ovr;
  logic [NB-1:0] n_data;
  logic [2:0]    n_idx;

  mvm_requant_out #(.SHIFT(SHIFT), .RELU_EN(1'b1)) dut_r (
    .i_clk_rqOut (clk),     .i_rst_rqOut (rst),   .i_y_vector (y),
    .i_isAcc     (isacc),   .o_busy      (r_busy), .o_data    (r_data),
    .o_valid     (r_valid), .i_ready     (ready), .o_idx      (r_idx),
    .o_last      (r_last),  .o_sat       (r_sat), .o_overrun  (r_ovr)
  );

  mvm_requant_out #(.SHIFT(SHIFT), .RELU_EN(1'b0)) dut_n (
    .i_clk_rqOut (clk),     .i_rst_rqOut (rst),   .i_y_vector (y),
    .i_isAcc     (isacc),   .o_busy      (n_busy), .o_data    (n_data),
    .o_valid     (n_valid), .i_ready     (ready), .o_idx      (n_idx),
    .o_last      (n_last),  .o_sat       (n_sat), .o_overrun  (n_ovr)
  );

  typedef struct {
    int data;
    bit sat;
    int idx;
  } item_t;

  item_t exp_r[$];
  item_t exp_n[$];
  int    pending;
  bit    ov_exp;
  bit    prev_acc;
  int    timeouts;
  bit    done;
  int    checks;
  int    errors;

  // Reference requantizer: floor division after half-LSB rounding, then clip.
  function automatic void ref_rq(input int acc, input bit relu, output int v, output bit s);
    int num, r, div;
    div = 2 ** SHIFT;
    num = acc + div / 2;
    r   = (num >= 0) ? num / div : -((-num + div - 1) / div);
    s   = 1'b0;
    if (relu && r < 0) v = 0;
    else if (r > 2 ** (NB-1) - 1) begin v = 2 ** (NB-1) - 1; s = 1'b1; end
    else if (r < -(2 ** (NB-1)))  begin v = -(2 ** (NB-1));   s = 1'b1; end
    else v = r;
  endfunction

  function automatic logic [AB-1:0] rand_acc();
    int v;
    case ($urandom % 4)
      0:       v = int'($urandom_range(0, 65535)) - 32768;
      1:       v = int'($urandom_range(0, 4095)) - 2048;
      2:       v = ($urandom % 2) ? int'($urandom_range(2016, 2064)) : -int'($urandom_range(2032, 2072));
      default: v = int'($urandom_range(0, 47)) - 24;
    endcase
    return AB'(v);
  endfunction

  task automatic model_reset();
    pending  = 0;
    ov_exp   = 1'b0;
    prev_acc = 1'b0;
    exp_r.delete();
    exp_n.delete();
  endtask

  task automatic capture_model();
    int v;
    bit s;
    for (int i = 0; i < DIM; i++) begin
      ref_rq(int'($signed(y[i])), 1'b1, v, s);
      exp_r.push_back('{data: v, sat: s, idx: i});
      ref_rq(int'($signed(y[i])), 1'b0, v, s);
      exp_n.push_back('{data: v, sat: s, idx: i});
    end
    pending = DIM;
  endtask

  // Advance one clock; the model sees the same inputs the DUTs sample.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (pending > 0 && ready) pending--;
      if (prev_acc && !isacc) begin
        if (pending == 0) capture_model();
        else ov_exp = 1'b1;
      end
      prev_acc = isacc;
    end
    #1;
  endtask

  task automatic pulse();
    isacc = 1'b1;
    cycle();
    isacc = 1'b0;
    cycle();
  endtask

  task automatic wait_pending(input int n);
    for (int k = 0; k < 200 && pending != n; k++) cycle();
    if (pending != n) timeouts++;
  endtask

  task automatic rand_vec();
    for (int i = 0; i < DIM; i++) y[i] = rand_acc();
  endtask

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic mon(input string tag, input bit norelu, input logic v, input logic b,
                     input logic ov, input logic [NB-1:0] d, input logic s,
                     input logic [2:0] ix, input logic l);
    item_t e;
    int    qn;
    chk({tag, "_valid"}, 32'(v), 32'(pending > 0));
    chk({tag, "_busy"}, 32'(b), 32'(pending > 0));
    chk({tag, "_overrun"}, 32'(ov), 32'(ov_exp));
    qn = norelu ? exp_n.size() : exp_r.size();
    if (pending > 0) begin
      if (qn == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_scoreboard actual=0 entries required>=1 t=%0t", tag, $time);
      end else begin
        e = norelu ? exp_n[0] : exp_r[0];
        chk({tag, "_data"}, 32'($signed(d)), e.data);
        chk({tag, "_sat"}, 32'(s), 32'(e.sat));
        chk({tag, "_idx"}, 32'(ix), e.idx);
        chk({tag, "_last"}, 32'(l), 32'(e.idx == DIM - 1));
        if (ready) begin
          if (norelu) void'(exp_n.pop_front());
          else void'(exp_r.pop_front());
        end
      end
    end else if (rst) begin
      chk({tag, "_rst_data"}, 32'(d), 0);
      chk({tag, "_rst_sat"}, 32'(s), 0);
      chk({tag, "_rst_last"}, 32'(l), 0);
      chk({tag, "_rst_idx"}, 32'(ix), 0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        chk("drain_relu", exp_r.size(), 0);
        chk("drain_norelu", exp_n.size(), 0);
        chk("wait_timeouts", timeouts, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      mon("relu", 1'b0, r_valid, r_busy, r_ovr, r_data, r_sat, r_idx, r_last);
      mon("norelu", 1'b1, n_valid, n_busy, n_ovr, n_data, n_sat, n_idx, n_last);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required<200000", $time);
    $fatal(1, "bench stalled");
  end

  initial begin
    rst      = 1'b1;
    isacc    = 1'b0;
    ready    = 1'b1;
    y        = '0;
    timeouts = 0;
    done     = 1'b0;
    model_reset();
    repeat (3) cycle();
    rst = 1'b0;
    repeat (3) cycle();

    // Fixed vector, full-rate drain (checked with and without ReLU).
    y[0] = 16'd72;   y[1] = 16'hFFE8; y[2] = 16'h7FFF; y[3] = 16'h8000;
    y[4] = 16'd8;    y[5] = 16'd7;    y[6] = 16'hFFF8; y[7] = 16'd256;
    pulse();
    wait_pending(0);
    repeat (2) cycle();

    // Backpressure for three cycles while element 2 is presented.
    pulse();
    wait_pending(DIM - 2);
    ready = 1'b0;
    repeat (3) cycle();
    ready = 1'b1;
    wait_pending(0);
    cycle();

    // New vector falls exactly on the last handshake.
    pulse();
    wait_pending(2);
    isacc = 1'b1;
    cycle();
    isacc = 1'b0;
    rand_vec();
    cycle();
    wait_pending(0);
    cycle();

    // New vector falls mid-stream at element 4 and is dropped.
    rand_vec();
    pulse();
    wait_pending(5);
    isacc = 1'b1;
    cycle();
    isacc = 1'b0;
    rand_vec();
    cycle();
    wait_pending(0);
    repeat (3) cycle();

    // Asynchronous reset while element 3 is presented.
    pulse();
    wait_pending(5);
    #1;
    rst = 1'b1;
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    repeat (4) cycle();
    isacc = 1'b1;
    repeat (6) cycle();
    isacc = 1'b0;
    rand_vec();
    cycle();
    wait_pending(0);
    cycle();

    // Random traffic: busy-flag toggles, stalls, and varied magnitudes.
    for (int c = 0; c < 400; c++) begin
      isacc = (($urandom % 3) == 0);
      ready = (($urandom % 4) != 0);
      rand_vec();
      cycle();
    end
    isacc = 1'b0;
    ready = 1'b1;
    cycle();
    wait_pending(0);
    repeat (2) cycle();
    done = 1'b1;
  end

endmodule

// File: doc/mvm_requant_out.md
Name: mvm_requant_out

Overview:
- Downstream stage of the matrix-vector multiply core.
- On the falling edge of the core's accumulate-busy flag, captures the DIM-wide vector of ACC_BIT-bit results.
- Requantizes each element to NUM_BIT signed fixed point with a rounding right shift, optional ReLU and saturation.
- Streams the DIM bytes out one per handshake to the next layer's loader, and exerts busy back to the controller so no new MVM starts before the buffer drains.

Parameters:
- NUM_BIT, 8, output element width (signed).
- DIM, 8, elements per result vector.
- ACC_BIT, 16, input accumulator width (signed, equals NUM_BIT+8).
- SHIFT, 4, arithmetic right shift (fraction-bit difference between accumulator and output); 0 is legal.
- RELU_EN, 1, when 1, negative results clamp to 0.

Ports:
- i_clk_rqOut  in  1  clock, rising edge.
- i_rst_rqOut  in  1  reset, asynchronous, active-high.
- i_y_vector  in  [DIM-1:0][ACC_BIT-1:0]  MVM result vector; valid in the first cycle i_isAcc is low after being high.
- i_isAcc  in  1  MVM busy flag; the falling edge marks results ready.
- o_busy  out  1  high while buffer holds unsent data; the controller must not pulse start while high.
- o_data  out  NUM_BIT  requantized element.
- o_valid  out  1  o_data valid.
- i_ready  in  1  consumer accepts o_data.
- o_idx  out  $clog2(DIM)  element index of o_data.
- o_last  out  1  o_idx == DIM-1 while o_valid.
- o_sat  out  1  current element was saturated.
- o_overrun  out  1  sticky: a vector arrived while STREAM and was dropped.

Behaviour:
- Reset (async, any state): state=IDLE, isAcc_d=0, all outputs 0, buffer contents don't-care.
- Edge detect: isAcc_d registers i_isAcc. fall = isAcc_d & ~i_isAcc (combinational).
- Per-element requant (combinational, applied at capture):
  - r = (y + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, computed in ACC_BIT+1 bits.
  - If RELU_EN and r<0: r=0, sat=0.
  - Clamp to [-2^(NUM_BIT-1), 2^(NUM_BIT-1)-1]; sat=1 if clamped.
- States:
  - IDLE: o_valid=0, o_busy=0. On fall: capture all DIM results and sat flags into the buffer, idx=0, go to STREAM.
  - STREAM: o_valid=1, o_busy=1, o_data=buf[idx], o_sat=satbuf[idx], o_last=(idx==DIM-1).
    - Transfer = o_valid & i_ready; on transfer idx++.
    - On transfer with idx==DIM-1: go to IDLE.
- Latency: fall in cycle N → capture at the edge ending N → o_valid=1 with element 0 in cycle N+1. Full drain is DIM cycles with i_ready held high.
- Backpressure: while o_valid & ~i_ready, o_data, o_idx, o_sat and o_last hold stable.
- Simultaneous last transfer and fall: capture the new vector, idx=0, stay in STREAM. o_valid stays high, no bubble. Not an overrun.
- Fall in STREAM not on the last transfer: new vector dropped, buffer unchanged, o_overrun←1. It stays 1 until reset.
- i_isAcc held low or high indefinitely: no action. Only an edge triggers capture.
- Reset mid-stream: outputs drop asynchronously. After release, the first fall is required before any output.

Decomposition:
- Package mvm_pkg holds:
  - NUM_BIT, DIM, ACC_BIT defaults.
  - The state enum {IDLE, STREAM}.
  - typedef acc_t (signed ACC_BIT) and act_t (signed NUM_BIT).
- Sub-module requant_unit: purely combinational, acc_t in → act_t and sat out, parameterized by SHIFT and RELU_EN. Instantiated DIM times in a generate loop.
- Top holds the FSM, edge detect, buffer and handshake.

Test Plan:
1. Defaults, i_y_vector = {72, -24, 0x7FFF, 0x8000, 8, 7, -8, 256}, i_ready=1, one isAcc pulse → o_data = 5, 0, 127(sat), 0, 1, 0, 0, 16 on consecutive cycles starting 1 cycle after fall. o_last only on the 8th.
2. Same vector with RELU_EN=0 → 5, -1 (0xFF), 127(sat), -128(sat), 1, 0, 0, 16.
3. i_ready low 3 cycles at idx=2 → o_data=127, o_idx=2, o_sat=1 stable for all 3 cycles. Stream completes 3 cycles later than in scenario 1.
4. Second fall coincident with the last transfer → element 0 of the new vector appears the next cycle, o_valid never drops, o_overrun=0.
5. Second fall at idx=4 → remaining elements are from the old vector, o_overrun=1 stays set, returns to IDLE after idx 7.
6. Assert i_rst_rqOut mid-edge at idx=3 → o_valid, o_busy and o_overrun read 0 immediately. No output until the next fall.
